// File: rtl/if_prefetch.sv
// Instruction-fetch prefetch queue: issues sequential word fetches to a one-cycle
// synchronous instruction memory and buffers the returned instructions for decode.
module if_prefetch #(
   parameter int unsigned        XLEN      = 32,
   parameter int unsigned        DEPTH     = 4,
   parameter logic [XLEN-1:0]    RESET_PC  = '0,
   parameter logic [31:0]        NOP_INSTR = 32'h0000_0013
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       is_flush,
   input  logic [XLEN-1:0]            branch_target,
   input  logic                       is_stall,
   output logic                       imem_req,
   output logic [XLEN-1:0]            imem_addr,
   input  logic [31:0]                imem_rdata,
   output logic                       is_valid,
   output logic [XLEN-1:0]            pc,
   output logic [31:0]                instr,
   output logic [$clog2(DEPTH+1)-1:0] count
);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH+1);

   logic [XLEN-1:0]             fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0]             req_pc_q, req_pc_d;
   logic                        pending_q, pending_d;
   logic [PW-1:0]               wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]               rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]               count_q, count_d;
   logic [DEPTH-1:0][XLEN-1:0]  q_pc_q, q_pc_d;
   logic [DEPTH-1:0][31:0]      q_ins_q, q_ins_d;

   logic [CW:0] inflight;
   logic        req, push, pop;
   logic        unused_tgt_bits;

   assign unused_tgt_bits = ^branch_target[1:0];

   // Credit: queued entries plus the one in flight must leave room for the new fetch.
   assign inflight = {1'b0, count_q} + {{CW{1'b0}}, pending_q};
   assign req      = reset & ~is_flush & (inflight < (CW+1)'(DEPTH));
   assign push     = pending_q & ~is_flush;
   assign pop      = (count_q != '0) & ~is_stall & ~is_flush;

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      req_pc_d   = req_pc_q;
      pending_d  = pending_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      q_pc_d     = q_pc_q;
      q_ins_d    = q_ins_q;
      if (is_flush) begin
         fetch_pc_d = {branch_target[XLEN-1:2], 2'b00};
         pending_d  = 1'b0;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
      end else begin
         pending_d = req;
         if (req) begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
            req_pc_d   = fetch_pc_q;
         end
         if (push) begin
            q_pc_d[wr_ptr_q]  = req_pc_q;
            q_ins_d[wr_ptr_q] = imem_rdata;
            wr_ptr_d          = wr_ptr_q + PW'(1);
         end
         if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetch_pc_q <= RESET_PC;
         req_pc_q   <= '0;
         pending_q  <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         q_pc_q     <= '0;
         q_ins_q    <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         req_pc_q   <= req_pc_d;
         pending_q  <= pending_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         q_pc_q     <= q_pc_d;
         q_ins_q    <= q_ins_d;
      end
   end

   assign imem_req  = req;
   assign imem_addr = fetch_pc_q;
   assign count     = count_q;
   assign is_valid  = (count_q != '0);
   assign pc        = is_valid ? q_pc_q[rd_ptr_q]  : '0;
   assign instr     = is_valid ? q_ins_q[rd_ptr_q] : NOP_INSTR;

   // A push into a full queue without a pop means the credit rule was broken.
   a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
      !(push && !pop && (count_q == CW'(DEPTH))));
endmodule
